bsg_abs_pipe: RTL and testbench
===============================

Name: bsg_abs_pipe

Overview:
- Pipelined, parametrised absolute-value unit with valid/ready input and valid/yumi output handshakes.
- Successor to the combinational abs block. Adds:
  - configurable width and pipeline depth
  - per-transaction signed/unsigned mode
  - optional saturation of the most-negative input
  - sign and overflow flags per result
- Sits between a producer datapath (e.g. a difference unit) and a consumer accumulator; absorbs backpressure without dropping data.

Parameters:
- width_p, 16: operand and result width in bits; legal range 2..64.
- stages_p, 2: pipeline register stages between accept and v_o; legal range 1..4.
- saturate_p, 1: 1 = most-negative signed input yields the max positive value; 0 = two's-complement wrap (result equals input).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  1  input valid.
- a_i  in  width_p  operand.
- signed_i  in  1  1 = treat a_i as two's complement; 0 = unsigned pass-through.
- ready_o  out  1  block can accept this cycle.
- v_o  out  1  result valid at final stage.
- o  out  width_p  magnitude result.
- neg_o  out  1  operand was negative (signed_i=1 and a_i[MSB]=1).
- ovf_o  out  1  operand was the most-negative signed value.
- yumi_i  in  1  consumer takes the result this cycle; legal only when v_o=1.

Behaviour:
- Reset (async assert, sync deassert at the integration level): all stage valid bits clear immediately; all data, flag and output registers go to 0.
  - Outputs during reset: v_o=0, o=0, neg_o=0, ovf_o=0, ready_o=1.
  - Any in-flight transactions are discarded.
- Arithmetic, performed combinationally before stage 0 register:
  - signed_i=0: mag=a_i, neg=0, ovf=0.
  - signed_i=1 and a_i[MSB]=0: mag=a_i, neg=0, ovf=0.
  - signed_i=1 and a_i[MSB]=1: mag=(~a_i)+1 truncated to width_p, neg=1.
  - ovf=1 iff a_i==1 followed by width_p-1 zeros (the most-negative value). Then mag = saturate_p ? 0 followed by width_p-1 ones : a_i.
- Pipeline:
  - stages_p stages, each holding {valid, neg, ovf, mag}. Final stage drives v_o/o/neg_o/ovf_o directly from registers; no combinational path from a_i to outputs.
  - Stage k advance condition: stage k+1 is empty, or stage k+1 advances this cycle. Final stage advances when v_o & yumi_i.
  - Stage k that is not advancing holds its contents.
  - ready_o = stage 0 empty OR stage 0 advances. Combinational from yumi_i is permitted (full-throughput chain).
  - Accept = v_i & ready_o. On accept, stage 0 loads the computed result with valid=1. If not accepting and stage 0 advances, stage 0 valid clears.
- Latency and throughput:
  - Latency: exactly stages_p cycles from accept edge to v_o=1 when unstalled.
  - Throughput: 1 result/cycle with yumi_i held high.
  - Capacity: stages_p results in flight.
- Boundary conditions:
  - Full pipeline with yumi_i=0: ready_o=0; v_i is ignored and the producer must hold.
  - Full pipeline with yumi_i=1 and v_i=1 in the same cycle: the result is consumed and a new operand is accepted; occupancy is unchanged.
  - Zero input: o=0, neg_o=0, ovf_o=0.
  - yumi_i while v_o=0: illegal; the bench asserts on it, and the RTL ignores it.
  - Ordering: results always leave in acceptance order.
- Reset mid-operation: all valids drop within the reset-assertion cycle, independent of clk_i. After release, the first accept sees an empty pipeline.

Decomposition:
- Package bsg_abs_pipe_pkg:
  - struct abs_result_s {neg, ovf, mag[width_p-1:0]}, or a width-parametrised equivalent via a macro.
  - function abs_compute(a, signed, saturate) returning abs_result_s, shared by RTL and the bench's reference model.
- Sub-module bsg_abs_pipe_stage:
  - one valid/data register stage with advance/hold logic and async active-low reset.
  - instantiated stages_p times via generate.

Test Plan:
- Basic signed, width_p=16, stages_p=2, yumi_i=1: a_i=0xFFFB, signed_i=1 -> two cycles later v_o=1, o=0x0005, neg_o=1, ovf_o=0.
- Unsigned pass-through: a_i=0xFFFB, signed_i=0 -> o=0xFFFB, neg_o=0, ovf_o=0; and a_i=0x0000 -> o=0, all flags 0.
- Most-negative value, a_i=0x8000, signed_i=1:
  - saturate_p=1 -> o=0x7FFF, neg_o=1, ovf_o=1.
  - saturate_p=0 -> o=0x8000, ovf_o=1.
- Backpressure:
  - stream 0xFFFF, 0x0003, 0xFFF0, 0x0007 with yumi_i=0 -> ready_o drops after 2 accepts.
  - then raise yumi_i -> outputs 0x0001, 0x0003, 0x0010, 0x0007 in order, no loss or duplication, 1/cycle once flowing.
- Simultaneous accept/consume on full pipe (stages_p=3): v_i=1 and yumi_i=1 each cycle for 20 cycles with random a_i -> ready_o stays 1 and all outputs match abs_compute in order.
- Reset mid-operation: assert reset_n_i=0 asynchronously with 2 entries in flight -> v_o=0, o=0, ready_o=1 before the next clk edge. After release, one accept of 0x0009 -> o=0x0009 after stages_p cycles, with no stale data.

Source files
------------

// File: rtl/bsg_abs_pipe_pkg.sv
// Shared types and the absolute-value rule for bsg_abs_pipe.
// abs_compute works on a 64-bit container; callers pass their real width.
package bsg_abs_pipe_pkg;

  localparam int unsigned max_width_lp = 64;

  // Low bits are {.., neg, ovf} so a width cast keeps {mag[width-1:0], neg, ovf}.
  typedef struct packed {
    logic [max_width_lp-1:0] mag;
    logic                    neg;
    logic                    ovf;
  } abs_result_s;

  function automatic abs_result_s abs_compute(input logic [max_width_lp-1:0] a,
                                              input int unsigned             width,
                                              input logic                    is_signed,
                                              input logic                    saturate);
    logic [max_width_lp-1:0] min_neg;
    logic [max_width_lp-1:0] mask;
    logic [max_width_lp-1:0] a_m;
    abs_result_s             r;
    min_neg = 64'(1) << (width - 1);
    mask    = (min_neg << 1) - 64'(1);
    a_m     = a & mask;
    r.neg   = is_signed & (|(a_m & min_neg));
    r.ovf   = r.neg & (a_m == min_neg);
    if (r.ovf)      r.mag = saturate ? (min_neg - 64'(1)) : a_m;
    else if (r.neg) r.mag = (~a_m + 64'(1)) & mask;
    else            r.mag = a_m;
    return r;
  endfunction

endpackage

// File: rtl/bsg_abs_pipe_stage.sv
// One valid/data pipeline register: loads when empty or when its content leaves.
module bsg_abs_pipe_stage #(
  parameter int unsigned data_width_p = 18
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    ready_c,
  input  logic                    yumi_i,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o
);

  assign ready_c = ~v_o | yumi_i;

  // Data only moves on a real load so the output holds its last value when idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
    end else if (ready_c) begin
      v_o <= v_i;
      if (v_i) data_o <= data_i;
    end
  end

endmodule

// File: rtl/bsg_abs_pipe.sv
// Pipelined absolute-value unit: valid/ready in, valid/yumi out, stages_p deep.
module bsg_abs_pipe
  import bsg_abs_pipe_pkg::*;
#(
  parameter int unsigned width_p    = 16,
  parameter int unsigned stages_p   = 2,
  parameter bit          saturate_p = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] a_i,
  input  logic               signed_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] o,
  output logic               neg_o,
  output logic               ovf_o,
  input  logic               yumi_i
);

  localparam int unsigned data_width_lp = width_p + 2;

  // Index k is the input side of stage k; index stages_p is the final output.
  logic [stages_p:0]        up_v;
  logic [data_width_lp-1:0] up_data [stages_p+1];
  logic [stages_p:0]        down_rdy;

  assign up_v[0]            = v_i;
  assign up_data[0]         = data_width_lp'(abs_compute(64'(a_i), width_p, signed_i, saturate_p));
  assign down_rdy[stages_p] = yumi_i;
  assign ready_o            = down_rdy[0];

  for (genvar k = 0; k < stages_p; k++) begin : g_stage
    // Consumer yumi is qualified by v_o so a stray yumi on an empty slot is ignored.
    bsg_abs_pipe_stage #(.data_width_p(data_width_lp)) stage (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (up_v[k]),
      .data_i   (up_data[k]),
      .ready_c  (down_rdy[k]),
      .yumi_i   (up_v[k+1] & down_rdy[k+1]),
      .v_o      (up_v[k+1]),
      .data_o   (up_data[k+1])
    );
  end

  assign v_o                = up_v[stages_p];
  assign {o, neg_o, ovf_o}  = up_data[stages_p];

endmodule

// File: tb/tb_bsg_abs_pipe.sv
// Directed + randomized bench for bsg_abs_pipe against an arithmetic reference.
// Three instances cover (stages 2, sat 1), (stages 2, sat 0), (stages 3, sat 1).
module tb_bsg_abs_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_i;
  logic [15:0] a_i;
  logic        signed_i;
  logic        yumi_en;
  logic [2:0]  ready_a, v_o_a, neg_a, ovf_a, yumi_a;
  logic [15:0] o_a [3];

  int          sel;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [17:0] exp_q [$];
  logic [16:0] feed_q [$];

  always #5 clk = ~clk;

  // The consumer only takes a result when one is offered.
  assign yumi_a = {3{yumi_en}} & v_o_a;

  bsg_abs_pipe #(.width_p(16), .stages_p(2), .saturate_p(1'b1)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .a_i(a_i), .signed_i(signed_i),
    .ready_o(ready_a[0]), .v_o(v_o_a[0]), .o(o_a[0]), .neg_o(neg_a[0]),
    .ovf_o(ovf_a[0]), .yumi_i(yumi_a[0]));

  bsg_abs_pipe #(.width_p(16), .stages_p(2), .saturate_p(1'b0)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .a_i(a_i), .signed_i(signed_i),
    .ready_o(ready_a[1]), .v_o(v_o_a[1]), .o(o_a[1]), .neg_o(neg_a[1]),
    .ovf_o(ovf_a[1]), .yumi_i(yumi_a[1]));

  bsg_abs_pipe #(.width_p(16), .stages_p(3), .saturate_p(1'b1)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .a_i(a_i), .signed_i(signed_i),
    .ready_o(ready_a[2]), .v_o(v_o_a[2]), .o(o_a[2]), .neg_o(neg_a[2]),
    .ovf_o(ovf_a[2]), .yumi_i(yumi_a[2]));

  // Reference: {neg, ovf, mag} from the plain integer value of the operand.
  function automatic logic [17:0] ref_abs(input logic [15:0] a, input bit sgn, input bit sat);
    int val;
    if (!sgn || a < 16'h8000) return {1'b0, 1'b0, a};
    val = int'(a) - 65536;
    if (val == -32768) return {1'b1, 1'b1, (sat ? 16'h7FFF : a)};
    return {1'b1, 1'b0, 16'(-val)};
  endfunction

  function automatic bit sat_of(input int s);
    return (s != 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    if (feed_q.size() > 0) begin
      v_i = 1'b1;
      {signed_i, a_i} = feed_q[0];
    end else begin
      v_i = 1'b0;
    end
  endtask

  task automatic push(input logic [15:0] a, input logic s);
    feed_q.push_back({s, a});
    apply_inputs();
  endtask

  // One clock: score any consumed result, record any accept, then advance.
  task automatic tick();
    logic [17:0] e;
    #2;
    if (v_o_a[sel] && yumi_a[sel]) begin
      chk("result_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o", 64'(o_a[sel]), 64'(e[15:0]));
        chk("neg_o", 64'(neg_a[sel]), 64'(e[17]));
        chk("ovf_o", 64'(ovf_a[sel]), 64'(e[16]));
      end
    end
    if (v_i && ready_a[sel]) begin
      exp_q.push_back(ref_abs(a_i, signed_i, sat_of(sel)));
      void'(feed_q.pop_front());
    end
    @(posedge clk);
    #1;
    apply_inputs();
  endtask

  task automatic drain();
    yumi_en = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() > 0 || feed_q.size() > 0); i++) tick();
    chk("drained", 64'(exp_q.size() + feed_q.size()), 64'(0));
  endtask

  task automatic do_reset(input int s);
    rst_n   = 1'b0;
    yumi_en = 1'b0;
    feed_q.delete();
    exp_q.delete();
    apply_inputs();
    sel = s;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; v_i = 1'b0; a_i = '0; signed_i = 1'b0; yumi_en = 1'b0; sel = 0;
    #3;
    for (int k = 0; k < 3; k++) begin
      chk("rst_v_o", 64'(v_o_a[k]), 64'(0));
      chk("rst_o", 64'(o_a[k]), 64'(0));
      chk("rst_neg_o", 64'(neg_a[k]), 64'(0));
      chk("rst_ovf_o", 64'(ovf_a[k]), 64'(0));
      chk("rst_ready_o", 64'(ready_a[k]), 64'(1));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic signed with two-cycle latency
    yumi_en = 1'b1;
    push(16'hFFFB, 1'b1);
    tick();
    chk("lat_v_o_early", 64'(v_o_a[0]), 64'(0));
    tick();
    chk("lat_v_o", 64'(v_o_a[0]), 64'(1));
    chk("basic_o", 64'(o_a[0]), 64'(16'h0005));
    chk("basic_neg", 64'(neg_a[0]), 64'(1));
    chk("basic_ovf", 64'(ovf_a[0]), 64'(0));
    drain();

    // Unsigned pass-through and zero
    push(16'hFFFB, 1'b0);
    push(16'h0000, 1'b0);
    push(16'h0000, 1'b1);
    drain();

    // Most-negative value, saturating
    push(16'h8000, 1'b1);
    tick(); tick();
    chk("sat_o", 64'(o_a[0]), 64'(16'h7FFF));
    chk("sat_neg", 64'(neg_a[0]), 64'(1));
    chk("sat_ovf", 64'(ovf_a[0]), 64'(1));
    drain();

    // Most-negative value, wrapping
    do_reset(1);
    yumi_en = 1'b1;
    push(16'h8000, 1'b1);
    tick(); tick();
    chk("wrap_o", 64'(o_a[1]), 64'(16'h8000));
    chk("wrap_ovf", 64'(ovf_a[1]), 64'(1));
    chk("wrap_neg", 64'(neg_a[1]), 64'(1));
    drain();

    // Backpressure: fill, stall, then release at full rate
    do_reset(0);
    push(16'hFFFF, 1'b1); push(16'h0003, 1'b1); push(16'hFFF0, 1'b1); push(16'h0007, 1'b1);
    tick(); tick();
    chk("bp_ready_low", 64'(ready_a[0]), 64'(0));
    chk("bp_in_flight", 64'(exp_q.size()), 64'(2));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ready", 64'(ready_a[0]), 64'(0));
    end
    chk("bp_held", 64'(feed_q.size()), 64'(2));
    yumi_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_flow_v_o", 64'(v_o_a[0]), 64'(1));
      tick();
    end
    chk("bp_empty_v_o", 64'(v_o_a[0]), 64'(0));
    drain();

    // Three-stage pipe: accept and consume every cycle
    do_reset(2);
    yumi_en = 1'b1;
    for (int i = 0; i < 23; i++) push(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 23; i++) begin
      chk("stream_ready", 64'(ready_a[2]), 64'(1));
      tick();
    end
    drain();

    // Random backpressure on the wrapping instance
    do_reset(1);
    push(16'h8000, 1'b1); push(16'h0000, 1'b1); push(16'h7FFF, 1'b1); push(16'h8001, 1'b1);
    for (int i = 0; i < 40; i++) push(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 400 && (exp_q.size() > 0 || feed_q.size() > 0); i++) begin
      yumi_en = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Reset with two results in flight
    do_reset(0);
    push(16'h1234, 1'b1); push(16'h00FF, 1'b0);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v_o", 64'(v_o_a[0]), 64'(0));
    chk("mid_rst_o", 64'(o_a[0]), 64'(0));
    chk("mid_rst_neg", 64'(neg_a[0]), 64'(0));
    chk("mid_rst_ovf", 64'(ovf_a[0]), 64'(0));
    chk("mid_rst_ready", 64'(ready_a[0]), 64'(1));
    do_reset(0);
    yumi_en = 1'b1;
    push(16'h0009, 1'b1);
    tick();
    chk("post_rst_v_early", 64'(v_o_a[0]), 64'(0));
    tick();
    chk("post_rst_v_o", 64'(v_o_a[0]), 64'(1));
    chk("post_rst_o", 64'(o_a[0]), 64'(16'h0009));
    drain();
    tick();
    chk("post_rst_no_stale", 64'(v_o_a[0]), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
